// File: rtl/inst_encoder_if.sv
// Handshake bundle for the RV32I instruction encoder: decoded fields in,
// encoded word/address out, plus the address-load side channel.
interface inst_encoder_if #(parameter int ERRCNT_W = 8);
   logic                in_valid;
   logic                in_ready;
   logic [2:0]          fmt;
   logic [6:0]          opcode;
   logic [4:0]          rd;
   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [2:0]          funct3;
   logic [6:0]          funct7;
   logic [31:0]         imm;
   logic                addr_load;
   logic [31:0]         addr_in;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_inst;
   logic [31:0]         out_addr;
   logic                out_err;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             addr_load, addr_in, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
   );

   modport slave (
      input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             addr_load, addr_in, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err, err_count
   );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: range-checks and scatters an immediate into its
// format, tags the word with a sequential address and queues it in a 2-deep FIFO.
module inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ERRCNT_W  = 8
) (
   input logic          clk,
   input logic          rst,
   inst_encoder_if.slave bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        err;
   } entry_t;

   entry_t              head_q, head_d, tail_q, tail_d, new_e;
   logic [1:0]          count_q, count_d;
   logic [31:0]         addr_q, addr_d, ent_addr, load_addr;
   logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
   logic [31:0]         imm, enc;
   logic                err, push, pop;
   logic signed [31:0]  simm;

   assign imm  = bus.imm;
   assign simm = $signed(bus.imm);

   always_comb begin
      enc = NOP;
      err = 1'b0;
      case (bus.fmt)
         3'b000: begin
            enc = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            err = (simm < -32'sd2048) || (simm > 32'sd2047);
         end
         3'b001: begin
            enc = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
            err = (simm < -32'sd2048) || (simm > 32'sd2047);
         end
         3'b101: begin
            enc = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], bus.opcode};
            err = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
         end
         3'b010: begin
            enc = {imm[31:12], bus.rd, bus.opcode};
            err = (imm[11:0] != 12'd0);
         end
         3'b011: begin
            enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
            err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
         end
         3'b100: begin
            enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
         default: begin
            enc = NOP;
            err = 1'b1;
         end
      endcase
   end

   assign push      = bus.in_valid && (count_q < 2'd2);
   assign pop       = (count_q != 2'd0) && bus.out_ready;
   assign load_addr = {bus.addr_in[31:2], 2'b00};
   assign ent_addr  = bus.addr_load ? load_addr : addr_q;
   assign new_e     = '{inst: enc, addr: ent_addr, err: err};

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      addr_d   = addr_q;
      errcnt_d = errcnt_q;
      if (push) addr_d = ent_addr + 32'd4;
      else if (bus.addr_load) addr_d = load_addr;
      if (push && err && !(&errcnt_q)) errcnt_d = errcnt_q + 1'b1;
      // Head always holds the oldest entry; tail is only used when two are queued.
      case (count_q)
         2'd0: if (push) begin
            head_d  = new_e;
            count_d = 2'd1;
         end
         2'd1: begin
            if (push && pop) head_d = new_e;
            else if (push) begin
               tail_d  = new_e;
               count_d = 2'd2;
            end else if (pop) count_d = 2'd0;
         end
         default: if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= 2'd0;
         addr_q   <= BASE_ADDR;
         errcnt_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign bus.in_ready  = (count_q < 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_inst  = head_q.inst;
   assign bus.out_addr  = head_q.addr;
   assign bus.out_err   = head_q.err;
   assign bus.err_count = errcnt_q;
endmodule
